// File: rtl/rib_timer_pkg.sv
// -----------------------------------------------------------------------------
// rib_timer_pkg
// Shared definitions for the rib timer peripheral: bus widths, register word
// offsets, CTRL/STATUS bit indices, the CTRL register layout and the
// address decoder used by both the read and write paths.
// -----------------------------------------------------------------------------
package rib_timer_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  // Register word offsets (addr[4:2]).
  typedef enum logic [2:0] {
    TIMER_CTRL     = 3'd0,
    TIMER_COUNT    = 3'd1,
    TIMER_CMP      = 3'd2,
    TIMER_STATUS   = 3'd3,
    TIMER_PRESCALE = 3'd4
  } reg_sel_e;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int CTRL_PERIODIC_BIT  = 2;
  localparam int STATUS_PENDING_BIT = 0;

  // Field order matches the CTRL bit positions, so the struct can be placed
  // directly into the low bits of the read data.
  typedef struct packed {
    logic periodic;
    logic irq_en;
    logic en;
  } ctrl_t;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  // word_addr is addr[27:2]; bits above the register window must be zero.
  function automatic reg_dec_t decode_word(input logic [25:0] word_addr);
    reg_dec_t dec;
    dec.hit = (word_addr[25:3] == 23'd0) && (word_addr[2:0] <= 3'd4);
    dec.sel = dec.hit ? reg_sel_e'(word_addr[2:0]) : TIMER_CTRL;
    return dec;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock by (divisor_i + 1) while enabled and emits a one-clock
// tick. The internal counter is held at zero while disabled and restarts from
// zero whenever clear_i is asserted.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en_i       prescaler enable (CTRL.en)
//   clear_i    restart the divider from zero on this edge
//   divisor_i  terminal count; 0 gives a tick every clock
//   tick_o     one-clock tick, asserted while the counter equals divisor_i
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [PRESCALE_W-1:0] divisor_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;

  // Tick depends only on registered state, so the timer has no combinational
  // path from bus inputs to its outputs.
  assign tick_o = en_i && (pre_cnt_q == divisor_i);

  // NOTE: every path assigns pre_cnt_d, starting from a default, so no latch
  // can be inferred in this combinational block.
  always_comb begin
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    if (!en_i || clear_i || tick_o) begin
      pre_cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/rib_timer.sv
// -----------------------------------------------------------------------------
// rib_timer
// Memory-mapped timer on rib slave port 4. Holds a prescaled 32-bit
// up-counter with compare match, one-shot and periodic modes, a sticky
// pending flag and a level interrupt. Reads are registered: the address
// sampled at one edge returns its data during the following cycle.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   wr_en_i    write strobe from rib
//   wr_addr_i  write address (bits [31:28] are zero from rib)
//   wr_data_i  write data
//   rd_addr_i  read address, sampled every clock
//   rd_data_o  registered read data for the previous cycle's rd_addr_i
//   irq_o      level interrupt = STATUS.pending & CTRL.irq_en
//
// Register map (word offsets addr[4:2], addr[27:5] must be zero):
//   0x00 CTRL      bit0 en, bit1 irq_en, bit2 periodic
//   0x04 COUNT     current count
//   0x08 CMP       compare value
//   0x0C STATUS    bit0 pending, write 1 to clear
//   0x10 PRESCALE  divisor in bits [PRESCALE_W-1:0]
// -----------------------------------------------------------------------------
module rib_timer
  import rib_timer_pkg::*;
#(
  parameter int                       PRESCALE_W = 16,
  parameter logic [INST_DATA_BUS-1:0] CMP_RESET  = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [INST_ADDR_BUS-1:0] wr_addr_i,
  input  logic [INST_DATA_BUS-1:0] wr_data_i,
  input  logic [INST_ADDR_BUS-1:0] rd_addr_i,
  output logic [INST_DATA_BUS-1:0] rd_data_o,
  output logic                     irq_o
);

  localparam int DATA_W = INST_DATA_BUS;

  ctrl_t                 ctrl_q,     ctrl_d;
  logic [DATA_W-1:0]     count_q,    count_d;
  logic [DATA_W-1:0]     cmp_q,      cmp_d;
  logic                  pending_q,  pending_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [DATA_W-1:0]     rd_data_q,  rd_data_d;

  reg_dec_t wr_dec;
  reg_dec_t rd_dec;
  logic     wr_ctrl, wr_count, wr_cmp, wr_status, wr_prescale;
  logic     tick;
  logic     match;
  logic     pre_clear;

  // rib strips the slave nibble and the byte lane bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr_i[31:28], wr_addr_i[1:0],
                              rd_addr_i[31:28], rd_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign wr_dec = decode_word(wr_addr_i[27:2]);
  assign rd_dec = decode_word(rd_addr_i[27:2]);

  assign wr_ctrl     = wr_en_i && wr_dec.hit && (wr_dec.sel == TIMER_CTRL);
  assign wr_count    = wr_en_i && wr_dec.hit && (wr_dec.sel == TIMER_COUNT);
  assign wr_cmp      = wr_en_i && wr_dec.hit && (wr_dec.sel == TIMER_CMP);
  assign wr_status   = wr_en_i && wr_dec.hit && (wr_dec.sel == TIMER_STATUS);
  assign wr_prescale = wr_en_i && wr_dec.hit && (wr_dec.sel == TIMER_PRESCALE);

  // Reprogramming the enable or the divisor restarts the prescale phase.
  assign pre_clear = wr_ctrl || wr_prescale;

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en_i      (ctrl_q.en),
    .clear_i   (pre_clear),
    .divisor_i (prescale_q),
    .tick_o    (tick)
  );

  assign match = (count_q == cmp_q);

  // ---------------------------------------------------------------------------
  // Next-state logic. Assignment order encodes the priorities: STATUS clear
  // first so a same-cycle match wins, then the tick update, then bus writes
  // to COUNT/CTRL so software wins over the tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    cmp_d      = cmp_q;
    pending_d  = pending_q;
    prescale_d = prescale_q;

    if (wr_status && wr_data_i[STATUS_PENDING_BIT]) begin
      pending_d = 1'b0;
    end

    if (tick) begin
      if (!match) begin
        count_d = count_q + 32'd1;
      end else begin
        pending_d = 1'b1;
        if (ctrl_q.periodic) begin
          count_d = '0;
        end else begin
          ctrl_d.en = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      ctrl_d.en       = wr_data_i[CTRL_EN_BIT];
      ctrl_d.irq_en   = wr_data_i[CTRL_IRQ_EN_BIT];
      ctrl_d.periodic = wr_data_i[CTRL_PERIODIC_BIT];
    end
    if (wr_count) begin
      count_d = wr_data_i;
    end
    if (wr_cmp) begin
      cmp_d = wr_data_i;
    end
    if (wr_prescale) begin
      prescale_d = wr_data_i[PRESCALE_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: built from the pre-edge registers, so a same-cycle write is not
  // visible until the following read.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    if (rd_dec.hit) begin
      case (rd_dec.sel)
        TIMER_CTRL:     rd_data_d = {{(DATA_W-3){1'b0}}, ctrl_q};
        TIMER_COUNT:    rd_data_d = count_q;
        TIMER_CMP:      rd_data_d = cmp_q;
        TIMER_STATUS:   rd_data_d[STATUS_PENDING_BIT] = pending_q;
        TIMER_PRESCALE: rd_data_d = DATA_W'(prescale_q);
        default:        rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      count_q    <= '0;
      cmp_q      <= CMP_RESET;
      pending_q  <= 1'b0;
      prescale_q <= '0;
      rd_data_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      pending_q  <= pending_d;
      prescale_q <= prescale_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign irq_o     = pending_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_rib_timer.sv
// -----------------------------------------------------------------------------
// tb_rib_timer
// Self-checking bench for rib_timer: a table of single-cycle register
// accesses, hand-written multi-cycle sequences for counting, wrap, priority
// and reset corners, then randomized traffic compared against a cycle-level
// behavioural model that tracks when the next tick is due.
// -----------------------------------------------------------------------------
module tb_rib_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic        irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  rib_timer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: registers plus the absolute cycle number of the next tick.
  // ---------------------------------------------------------------------------
  logic        m_en, m_irq_en, m_periodic, m_pending;
  logic [31:0] m_count, m_cmp;
  logic [15:0] m_prescale;
  longint      m_cyc = 0;
  longint      m_next_tick = 0;
  logic [31:0] exp_rd;
  logic        exp_irq;

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_periodic = 0; m_pending = 0;
    m_count = 0; m_cmp = 32'hFFFF_FFFF; m_prescale = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[27:5] != 0) return 32'h0;
    case (a[4:2])
      3'd0:    return {29'h0, m_periodic, m_irq_en, m_en};
      3'd1:    return m_count;
      3'd2:    return m_cmp;
      3'd3:    return {31'h0, m_pending};
      3'd4:    return {16'h0, m_prescale};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic we, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [31:0] ra);
    logic [31:0] rd_e;
    logic        w_hit, tick, match;
    logic        n_en, n_irq_en, n_periodic, n_pending;
    logic [31:0] n_count, n_cmp;
    logic [15:0] n_prescale;
    rd_e = r ? 32'h0 : model_read(ra);
    if (r) begin
      model_reset();
    end else begin
      w_hit = we && (wa[27:5] == 0);
      tick  = m_en && (m_cyc == m_next_tick);
      match = (m_count == m_cmp);
      n_en = m_en; n_irq_en = m_irq_en; n_periodic = m_periodic;
      n_pending = m_pending; n_count = m_count; n_cmp = m_cmp;
      n_prescale = m_prescale;
      if (w_hit && wa[4:2] == 3'd3 && wd[0]) n_pending = 0;
      if (tick) begin
        if (match) begin
          n_pending = 1;
          if (m_periodic) n_count = 0;
          else            n_en = 0;
        end else begin
          n_count = m_count + 1;
        end
        m_next_tick = m_cyc + 1 + longint'(m_prescale);
      end
      if (w_hit) begin
        case (wa[4:2])
          3'd0: begin
            n_en = wd[0]; n_irq_en = wd[1]; n_periodic = wd[2];
            m_next_tick = m_cyc + 1 + longint'(m_prescale);
          end
          3'd1: n_count = wd;
          3'd2: n_cmp = wd;
          3'd4: begin
            n_prescale = wd[15:0];
            m_next_tick = m_cyc + 1 + longint'(wd[15:0]);
          end
          default: ;
        endcase
      end
      m_en = n_en; m_irq_en = n_irq_en; m_periodic = n_periodic;
      m_pending = n_pending; m_count = n_count; m_cmp = n_cmp;
      m_prescale = n_prescale;
    end
    m_cyc++;
    exp_rd  = rd_e;
    exp_irq = m_pending && m_irq_en;
  endtask

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle.
  task automatic step(input logic r, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [31:0] ra);
    rst = r; wr_en_i = we; wr_addr_i = wa; wr_data_i = wd; rd_addr_i = ra;
    @(posedge clk);
    model_step(r, we, wa, wd, ra);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b0, 32'h0, 32'h0, a);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(5, 27));
    return a;
  endfunction

  function automatic logic [31:0] rand_data(input logic [31:0] a);
    case (a[4:2])
      3'd1:    return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : 32'($urandom_range(0, 12));
      3'd2:    return 32'($urandom_range(0, 12));
      3'd4:    return ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] wrap_seq [4];
    wrap_seq[0] = 32'hFFFF_FFFE; wrap_seq[1] = 32'hFFFF_FFFF;
    wrap_seq[2] = 32'h0;         wrap_seq[3] = 32'h1;

    // ---- register access table (timer stays disabled) -----------------------
    vecs.push_back('{0, 32'h00, 32'h0,         32'h00, 32'h0,         0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h04, 32'h0,         0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h08, 32'hFFFF_FFFF, 0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h0C, 32'h0,         0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h10, 32'h0,         0});
    vecs.push_back('{1, 32'h08, 32'h1234,      32'h08, 32'hFFFF_FFFF, 0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h08, 32'h1234,      0});
    vecs.push_back('{1, 32'h10, 32'h000A_BCDE, 32'h10, 32'h0,         0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h13, 32'h0000_BCDE, 0});
    vecs.push_back('{1, 32'h20, 32'hDEAD,      32'h14, 32'h0,         0});
    vecs.push_back('{1, 32'h1008, 32'h5,       32'h0A, 32'h1234,      0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h08, 32'h1234,      0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h808, 32'h0,        0});
    vecs.push_back('{1, 32'h00, 32'hFFFF_FFF8, 32'h00, 32'h0,         0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h00, 32'h0,         0});
    vecs.push_back('{1, 32'h04, 32'h77,        32'h04, 32'h0,         0});
    vecs.push_back('{0, 32'h00, 32'h0,         32'h04, 32'h77,        0});
    vecs.push_back('{1, 32'h0C, 32'h1,         32'h0C, 32'h0,         0});
    vecs.push_back('{1, 32'h10, 32'h0,         32'h10, 32'h0000_BCDE, 0});

    do_reset();
    do_reset();
    check("reset_rd", rd_data_o, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    foreach (vecs[i]) begin
      step(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra);
      check($sformatf("vec%0d_rd", i), rd_data_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'h0, irq_o}, {31'h0, vecs[i].exp_irq});
    end

    // ---- one-shot: PRESCALE=0, CMP=5, en+irq_en -----------------------------
    do_reset();
    wr(32'h08, 32'd5);
    wr(32'h00, 32'b011);
    for (int i = 0; i < 6; i++) begin
      rd(32'h04);
      check($sformatf("oneshot_count%0d", i), rd_data_o, 32'(i));
      check($sformatf("oneshot_irq%0d", i), {31'h0, irq_o}, {31'h0, (i == 5)});
    end
    rd(32'h00);
    check("oneshot_ctrl", rd_data_o, 32'h2);
    rd(32'h04);
    check("oneshot_hold", rd_data_o, 32'd5);
    rd(32'h0C);
    check("oneshot_status", rd_data_o, 32'h1);
    check("oneshot_irq_hold", {31'h0, irq_o}, 32'h1);

    // ---- periodic with PRESCALE=2, CMP=3 ------------------------------------
    do_reset();
    wr(32'h10, 32'd2);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'b111);
    for (int i = 0; i < 15; i++) begin
      rd(32'h04);
      check($sformatf("periodic_count%0d", i), rd_data_o, 32'((i / 3) % 4));
      check($sformatf("periodic_irq%0d", i), {31'h0, irq_o}, {31'h0, (i >= 11)});
    end
    step(1'b0, 1'b1, 32'h0C, 32'h1, 32'h0C);
    check("periodic_status_prewrite", rd_data_o, 32'h1);
    check("periodic_irq_cleared", {31'h0, irq_o}, 32'h0);
    rd(32'h0C);
    check("periodic_status_after", rd_data_o, 32'h0);

    // ---- wrap through FFFF_FFFF with CMP=1, periodic, no irq_en --------------
    do_reset();
    wr(32'h08, 32'd1);
    wr(32'h04, 32'hFFFF_FFFE);
    wr(32'h00, 32'b101);
    for (int i = 0; i < 4; i++) begin
      rd(32'h04);
      check($sformatf("wrap_count%0d", i), rd_data_o, wrap_seq[i]);
    end
    rd(32'h0C);
    check("wrap_pending", rd_data_o, 32'h1);
    check("wrap_irq_masked", {31'h0, irq_o}, 32'h0);

    // ---- match beats STATUS clear; COUNT write beats tick -------------------
    do_reset();
    wr(32'h08, 32'd2);
    wr(32'h00, 32'b111);
    rd(32'h04);
    check("prio_count0", rd_data_o, 32'd0);
    rd(32'h04);
    check("prio_count1", rd_data_o, 32'd1);
    step(1'b0, 1'b1, 32'h0C, 32'h1, 32'h04);
    check("prio_count2", rd_data_o, 32'd2);
    check("prio_irq", {31'h0, irq_o}, 32'h1);
    rd(32'h0C);
    check("prio_pending_kept", rd_data_o, 32'h1);
    step(1'b0, 1'b1, 32'h04, 32'd100, 32'h04);
    check("count_wr_old_value", rd_data_o, 32'd1);
    rd(32'h04);
    check("count_wr_wins", rd_data_o, 32'd100);
    rd(32'h04);
    check("count_after_wr", rd_data_o, 32'd101);

    // ---- reset while counting ------------------------------------------------
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h04);
    check("midreset_rd", rd_data_o, 32'h0);
    check("midreset_irq", {31'h0, irq_o}, 32'h0);
    rd(32'h08);
    check("midreset_cmp", rd_data_o, 32'hFFFF_FFFF);
    rd(32'h00);
    check("midreset_ctrl", rd_data_o, 32'h0);
    rd(32'h04);
    check("midreset_count", rd_data_o, 32'h0);

    // ---- randomized traffic against the model -------------------------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r, we;
      logic [31:0] wa, wd, ra;
      r  = ($urandom_range(0, 499) == 0);
      we = ($urandom_range(0, 3) == 0);
      wa = rand_addr();
      wd = rand_data(wa);
      ra = rand_addr();
      step(r, we, wa, wd, ra);
      check($sformatf("rand%0d_rd", i), rd_data_o, exp_rd);
      check($sformatf("rand%0d_irq", i), {31'h0, irq_o}, {31'h0, exp_irq});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
